fadd_result_fifo: RTL and testbench
===================================

// Module: fadd_result_fifo
// PURPOSE
//  Downstream stage of the pipelined bfloat16 adder (fadd). Captures each sum on the cycle the adder's
//  ready/valid strobe is high and buffers it in a DEPTH-entry FIFO for a consumer with a valid/ready handshake.
//  The adder cannot be stalled, so the block drops results on overflow and counts them.
//  It also keeps sticky NaN/Inf/zero status flags for the result stream.
// PARAMETERS
//  N       16  result width; must equal 1+EXP_W+MAN_W
//  EXP_W   8   exponent width
//  MAN_W   7   stored mantissa width
//  DEPTH   8   FIFO entries; power of 2, >=2
//  CNT_W   8   drop counter width
// PORTS
//  clock      in   1                 single clock, rising edge
//  reset      in   1                 synchronous, active-high
//  in_sum     in   N                 adder result {sign, exp, mantissa}
//  in_valid   in   1                 adder ready strobe; in_sum is valid this cycle
//  out_data   out  N                 FIFO head
//  out_class  out  3                 class of head (fp_class_e)
//  out_valid  out  1                 head valid
//  out_ready  in   1                 consumer accepts head when out_valid&&out_ready
//  level      out  $clog2(DEPTH)+1   current occupancy
//  drop_cnt   out  CNT_W             results dropped while full; saturates at all-ones
//  nan_seen   out  1                 sticky: a NaN was accepted
//  inf_seen   out  1                 sticky: an Inf was accepted
//  zero_seen  out  1                 sticky: a zero (+0 or -0) was accepted
//  clr_stat   in   1                 one-cycle pulse; clears drop_cnt and the sticky flags
// BEHAVIOUR
//  - Reset (sync, high): pointers=0, level=0, out_valid=0, out_data=0, out_class=0, drop_cnt=0, flags=0.
//    Reset in mid-stream discards all entries; an in_valid in the reset cycle is ignored.
//  - Push when in_valid && (!full || pop). Pop when out_valid && out_ready.
//  - Latency: a push into an empty FIFO drives out_valid high on the next cycle. There is no combinational bypass.
//  - out_data/out_class are registered head-of-queue values and hold stable while out_valid && !out_ready.
//  - Full with push and pop in the same cycle: both happen and level stays DEPTH. No drop.
//  - Empty with push and pop in the same cycle: pop is impossible (out_valid=0), so only the push takes effect.
//  - Full, no pop, in_valid: result discarded; drop_cnt += 1 unless all-ones.
//  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
//  - full = (level==DEPTH); empty = (level==0).
//  - Classification on accepted entries (e=exp field, m=mantissa field):
//      e==0 && m==0     -> FP_ZERO
//      e==0 && m!=0     -> FP_DENORM
//      e==all-1 && m==0 -> FP_INF
//      e==all-1 && m!=0 -> FP_NAN
//      otherwise        -> FP_NORM
//  - Sticky flags are set on accepted pushes only; dropped results do not set them.
//  - clr_stat in the same cycle as a set event: set wins, so the flag ends at 1.
//  - clr_stat in the same cycle as a drop: drop_cnt ends at 1.
// CONFIGURATION
//  FADD_RES_CLASSIFY_EN defined:
//    each entry stores a 3-bit class alongside the data (FIFO word N+3), and out_class shows the head's class.
//  FADD_RES_CLASSIFY_EN undefined:
//    the FIFO word is N bits and out_class is tied to 3'b000.
//    Sticky flags and drop counting are unchanged; they classify at the input, which is always present.
// STRUCTURE
//  fadd_pkg:
//    fp_class_e enum: FP_NORM=0, FP_ZERO=1, FP_DENORM=2, FP_INF=3, FP_NAN=4
//    FP_EXP_W=8, FP_MAN_W=7
//    bf16_t packed struct {sign, exp, man}
//  Sub-module fp_classify: combinational, in_sum -> fp_class_e. Shared by the input-side flag logic and the stored class.
//  FIFO storage is a register array with a read register. No vendor RAM.
// TESTING
//  1 Push 0x3F80, 0x4000, 0x4040 on consecutive cycles with out_ready=1:
//    out_data 0x3F80/0x4000/0x4040 on cycles 1-3 after each push; level never exceeds 1.
//  2 out_ready=0; push 10 results (DEPTH=8):
//    level=8, drop_cnt=2, out_data holds the first value.
//    Then one cycle with push+pop: level stays 8, drop_cnt stays 2.
//  3 Push 0x7FC0, 0xFF80, 0x8000, 0x0001:
//    nan_seen=inf_seen=zero_seen=1.
//    With the macro: out_class sequence 4,3,1,2.
//  4 clr_stat in the same cycle as a push of 0x7F80: inf_seen=1, drop_cnt=0.
//    Next cycle, clr_stat alone: inf_seen=0.
//  5 Fill 5 entries, assert reset for one cycle together with in_valid:
//    level=0, out_valid=0, drop_cnt=0, flags=0 on the next cycle.
//  6 Drop 260 results with CNT_W=8: drop_cnt saturates at 0xFF.
//    Run 3x DEPTH pushes and pops to exercise pointer wrap; data order is preserved.

Source files
------------

// File: rtl/fadd_pkg.sv
// Shared types for the bfloat16 adder datapath: the result class enum and the bf16 field layout.
package fadd_pkg;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 7;

    typedef enum logic [2:0] {
        FP_NORM   = 3'd0,
        FP_ZERO   = 3'd1,
        FP_DENORM = 3'd2,
        FP_INF    = 3'd3,
        FP_NAN    = 3'd4
    } fp_class_e;

    typedef struct packed {
        logic                sign;
        logic [FP_EXP_W-1:0] exp;
        logic [FP_MAN_W-1:0] man;
    } bf16_t;

endpackage

// File: rtl/fadd_result_fifo_if.sv
// Bundle of the result FIFO's data, handshake and status signals.
// The master side is the producer/consumer environment; the slave side is the FIFO.
interface fadd_result_fifo_if #(
    parameter int N     = 16,
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
);
    logic [N-1:0]             in_sum;
    logic                     in_valid;
    logic [N-1:0]             out_data;
    logic [2:0]               out_class;
    logic                     out_valid;
    logic                     out_ready;
    logic [$clog2(DEPTH):0]   level;
    logic [CNT_W-1:0]         drop_cnt;
    logic                     nan_seen;
    logic                     inf_seen;
    logic                     zero_seen;
    logic                     clr_stat;

    modport master (
        output in_sum, in_valid, out_ready, clr_stat,
        input  out_data, out_class, out_valid, level, drop_cnt, nan_seen, inf_seen, zero_seen
    );

    modport slave (
        input  in_sum, in_valid, out_ready, clr_stat,
        output out_data, out_class, out_valid, level, drop_cnt, nan_seen, inf_seen, zero_seen
    );
endinterface

// File: rtl/fp_classify.sv
// Combinational classifier for a {sign, exp, mantissa} float: zero, denormal, normal, infinity or NaN.
module fp_classify
    import fadd_pkg::*;
#(
    parameter int N     = 16,
    parameter int EXP_W = 8,
    parameter int MAN_W = 7
) (
    input  logic [N-1:0] sum_i,
    output fp_class_e    class_o
);

    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] man_f;
    logic             unused_sign;

    assign exp_f       = sum_i[N-2 -: EXP_W];
    assign man_f       = sum_i[MAN_W-1:0];
    assign unused_sign = sum_i[N-1];

    always_comb begin
        class_o = FP_NORM;
        if (exp_f == '0) begin
            class_o = (man_f == '0) ? FP_ZERO : FP_DENORM;
        end else if (&exp_f) begin
            class_o = (man_f == '0) ? FP_INF : FP_NAN;
        end
    end

endmodule

// File: rtl/fadd_result_fifo.sv
// Result FIFO behind the pipelined bf16 adder: drops and counts results on overflow, keeps sticky class flags.
// Define FADD_RES_CLASSIFY_EN to store each entry's class alongside the data and show it on out_class.
module fadd_result_fifo
    import fadd_pkg::*;
#(
    parameter int N     = 16,
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W,
    parameter int DEPTH = 8,
    parameter int CNT_W = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N-1:0]     in_sum,
    input  logic             in_valid,
    output logic [N-1:0]     out_data,
    output logic [2:0]       out_class,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LVL_W-1:0] level,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             nan_seen,
    output logic             inf_seen,
    output logic             zero_seen,
    input  logic             clr_stat
);

`ifdef FADD_RES_CLASSIFY_EN
    localparam int W_W = N + 3;
`else
    localparam int W_W = N;
`endif

    fp_class_e        in_cls;
    logic [W_W-1:0]   in_word;
    logic [W_W-1:0]   mem_q [DEPTH];
    logic [W_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             nan_q, nan_d;
    logic             inf_q, inf_d;
    logic             zero_q, zero_d;
    logic             full, push, pop, drop;

    fp_classify #(
        .N     (N),
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_classify (
        .sum_i   (in_sum),
        .class_o (in_cls)
    );

`ifdef FADD_RES_CLASSIFY_EN
    assign in_word   = {in_cls, in_sum};
    assign out_data  = head_q[N-1:0];
    assign out_class = head_q[N+2:N];
`else
    assign in_word   = in_sum;
    assign out_data  = head_q;
    assign out_class = FP_NORM;
`endif

    always_comb begin
        full     = (level_q == LVL_W'(DEPTH));
        pop      = out_valid_q && out_ready;
        push     = in_valid && (!full || pop);
        drop     = in_valid && full && !pop;
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
        out_valid_d = (level_d != '0);

        // The head register is refilled from the array, or straight from the input when
        // this cycle's write lands in the slot that becomes the new head.
        head_d = head_q;
        if (push && (wr_ptr_q == rd_ptr_d)) begin
            head_d = in_word;
        end else if (level_d != '0) begin
            head_d = mem_q[rd_ptr_d];
        end

        drop_cnt_d = drop_cnt_q;
        if (clr_stat) begin
            drop_cnt_d = drop ? CNT_W'(1) : '0;
        end else if (drop && !(&drop_cnt_q)) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end

        nan_d  = (nan_q  && !clr_stat) || (push && (in_cls == FP_NAN));
        inf_d  = (inf_q  && !clr_stat) || (push && (in_cls == FP_INF));
        zero_d = (zero_q && !clr_stat) || (push && (in_cls == FP_ZERO));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            out_valid_q <= 1'b0;
            head_q      <= '0;
            drop_cnt_q  <= '0;
            nan_q       <= 1'b0;
            inf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            out_valid_q <= out_valid_d;
            head_q      <= head_d;
            drop_cnt_q  <= drop_cnt_d;
            nan_q       <= nan_d;
            inf_q       <= inf_d;
            zero_q      <= zero_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= in_word;
        end
    end

    assign level     = level_q;
    assign out_valid = out_valid_q;
    assign drop_cnt  = drop_cnt_q;
    assign nan_seen  = nan_q;
    assign inf_seen  = inf_q;
    assign zero_seen = zero_q;

endmodule

// File: tb/tb_fadd_result_fifo.sv
// Bench for fadd_result_fifo: classification table, directed corner sequences and a random run
// checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_fadd_result_fifo;

    localparam int N       = 16;
    localparam int DEPTH   = 8;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    fadd_result_fifo_if #(.N(N), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    fadd_result_fifo #(
        .N(N), .EXP_W(8), .MAN_W(7), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_sum    (bus.in_sum),
        .in_valid  (bus.in_valid),
        .out_data  (bus.out_data),
        .out_class (bus.out_class),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .level     (bus.level),
        .drop_cnt  (bus.drop_cnt),
        .nan_seen  (bus.nan_seen),
        .inf_seen  (bus.inf_seen),
        .zero_seen (bus.zero_seen),
        .clr_stat  (bus.clr_stat)
    );

    int checks = 0;
    int passed = 0;

    // Reference model: an ordered queue of accepted results plus the status it implies.
    logic [N-1:0] mq [$];
    int           m_drop;
    bit           m_nan, m_inf, m_zero;

    typedef struct {
        logic [15:0] sum;
        int          cls;
    } vec_t;
    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act === want) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    endtask

    function automatic int cls_of(input logic [15:0] v);
        logic [7:0] e;
        logic [6:0] m;
        e = v[14:7];
        m = v[6:0];
        if (e == 8'h00) return (m == 0) ? 1 : 2;
        if (e == 8'hFF) return (m == 0) ? 3 : 4;
        return 0;
    endfunction

    function automatic int exp_cls(input int c);
`ifdef FADD_RES_CLASSIFY_EN
        return c;
`else
        return (c == 0) ? 0 : 0;
`endif
    endfunction

    task automatic compare_all(input string tag);
        check({tag, ".level"}, 32'(bus.level), mq.size());
        check({tag, ".valid"}, 32'(bus.out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            check({tag, ".data"},  32'(bus.out_data),  32'(mq[0]));
            check({tag, ".class"}, 32'(bus.out_class), exp_cls(cls_of(mq[0])));
        end
        check({tag, ".drop"}, 32'(bus.drop_cnt), m_drop);
        check({tag, ".flags"}, {29'd0, bus.nan_seen, bus.inf_seen, bus.zero_seen},
              {29'd0, m_nan, m_inf, m_zero});
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cyc(input logic [15:0] v, input bit iv, input bit rdy, input bit clr, input string tag);
        bit pop, push, drop;
        int c;
        bus.in_sum    = v;
        bus.in_valid  = iv;
        bus.out_ready = rdy;
        bus.clr_stat  = clr;
        pop  = (mq.size() != 0) && rdy;
        push = iv && ((mq.size() < DEPTH) || pop);
        drop = iv && !push;
        tick();
        bus.in_valid = 1'b0;
        bus.clr_stat = 1'b0;
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(v);
        if (clr) begin
            m_drop = drop ? 1 : 0;
            m_nan = 0; m_inf = 0; m_zero = 0;
        end else if (drop && m_drop < CNT_MAX) begin
            m_drop++;
        end
        if (push) begin
            c = cls_of(v);
            if (c == 4) m_nan = 1;
            if (c == 3) m_inf = 1;
            if (c == 1) m_zero = 1;
        end
        compare_all(tag);
    endtask

    task automatic rst_cyc(input bit iv, input logic [15:0] v, input string tag);
        bus.in_sum    = v;
        bus.in_valid  = iv;
        bus.out_ready = 1'b0;
        bus.clr_stat  = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.in_valid = 1'b0;
        mq.delete();
        m_drop = 0; m_nan = 0; m_inf = 0; m_zero = 0;
        compare_all(tag);
        check({tag, ".data0"},  32'(bus.out_data),  0);
        check({tag, ".class0"}, 32'(bus.out_class), 0);
    endtask

    initial begin
        logic [15:0] v;
        logic [15:0] specials [6];
        int seq [4];

        tbl[0] = '{16'h3F80, 0};
        tbl[1] = '{16'h0000, 1};
        tbl[2] = '{16'h8000, 1};
        tbl[3] = '{16'h0001, 2};
        tbl[4] = '{16'h807F, 2};
        tbl[5] = '{16'h7F80, 3};
        tbl[6] = '{16'hFF80, 3};
        tbl[7] = '{16'h7FC0, 4};
        tbl[8] = '{16'hFF81, 4};
        tbl[9] = '{16'h7F7F, 0};
        specials[0] = 16'h0000; specials[1] = 16'h8000; specials[2] = 16'h7F80;
        specials[3] = 16'hFFC1; specials[4] = 16'h0040; specials[5] = 16'h4040;
        seq[0] = 4; seq[1] = 3; seq[2] = 1; seq[3] = 2;

        bus.in_sum = '0; bus.in_valid = 0; bus.out_ready = 0; bus.clr_stat = 0;
        m_drop = 0; m_nan = 0; m_inf = 0; m_zero = 0;
        repeat (2) tick();
        rst_cyc(1'b0, 16'h0, "reset");

        // Classification table: clear, push one value, compare head and flags.
        for (int i = 0; i < 10; i++) begin
            cyc(16'h0, 0, 1, 1, "tbl.clr");
            cyc(tbl[i].sum, 1, 1, 0, "tbl.push");
            check("tbl.data",  32'(bus.out_data),  32'(tbl[i].sum));
            check("tbl.class", 32'(bus.out_class), exp_cls(tbl[i].cls));
            check("tbl.flags", {29'd0, bus.nan_seen, bus.inf_seen, bus.zero_seen},
                  {29'd0, tbl[i].cls == 4, tbl[i].cls == 3, tbl[i].cls == 1});
            $display("vec %0d: sum=0x%04h class=%0d flags=%b%b%b", i, tbl[i].sum, bus.out_class,
                     bus.nan_seen, bus.inf_seen, bus.zero_seen);
        end

        // Streaming with the consumer always ready: one-cycle latency, occupancy stays at 1.
        rst_cyc(1'b0, 16'h0, "s1.rst");
        cyc(16'h3F80, 1, 1, 0, "s1"); check("s1.d0", 32'(bus.out_data), 32'h3F80); check("s1.l0", 32'(bus.level), 1);
        cyc(16'h4000, 1, 1, 0, "s1"); check("s1.d1", 32'(bus.out_data), 32'h4000); check("s1.l1", 32'(bus.level), 1);
        cyc(16'h4040, 1, 1, 0, "s1"); check("s1.d2", 32'(bus.out_data), 32'h4040); check("s1.l2", 32'(bus.level), 1);
        cyc(16'h0, 0, 1, 0, "s1.drain");
        $display("seq1: streaming done, level=%0d", bus.level);

        // Overflow: 10 pushes into a stalled FIFO, then a simultaneous push and pop while full.
        rst_cyc(1'b0, 16'h0, "s2.rst");
        for (int i = 0; i < 10; i++) cyc(16'h4100 + 16'(i), 1, 0, 0, "s2.fill");
        check("s2.level", 32'(bus.level), 8);
        check("s2.drop",  32'(bus.drop_cnt), 2);
        check("s2.hold",  32'(bus.out_data), 32'h4100);
        cyc(16'h4200, 1, 1, 0, "s2.pp");
        check("s2.pp.level", 32'(bus.level), 8);
        check("s2.pp.drop",  32'(bus.drop_cnt), 2);
        check("s2.pp.data",  32'(bus.out_data), 32'h4101);
        $display("seq2: level=%0d drop_cnt=%0d", bus.level, bus.drop_cnt);

        // Special values set all sticky flags; stored classes follow the push order.
        rst_cyc(1'b0, 16'h0, "s3.rst");
        cyc(16'h7FC0, 1, 0, 0, "s3"); cyc(16'hFF80, 1, 0, 0, "s3");
        cyc(16'h8000, 1, 0, 0, "s3"); cyc(16'h0001, 1, 0, 0, "s3");
        check("s3.flags", {29'd0, bus.nan_seen, bus.inf_seen, bus.zero_seen}, 32'h7);
        for (int k = 0; k < 4; k++) begin
            check("s3.class", 32'(bus.out_class), exp_cls(seq[k]));
            cyc(16'h0, 0, 1, 0, "s3.pop");
        end
        $display("seq3: class sequence checked");

        // Clear racing a set and a drop.
        rst_cyc(1'b0, 16'h0, "s4.rst");
        for (int i = 0; i < 8; i++) cyc(16'h3C00 + 16'(i), 1, 0, 0, "s4.fill");
        cyc(16'h1234, 1, 0, 0, "s4.drop");
        cyc(16'h7F80, 1, 1, 1, "s4.clrset");
        check("s4.inf", 32'(bus.inf_seen), 1);
        check("s4.drop0", 32'(bus.drop_cnt), 0);
        cyc(16'h0, 0, 0, 1, "s4.clr");
        check("s4.inf0", 32'(bus.inf_seen), 0);
        cyc(16'h5555, 1, 0, 1, "s4.clrdrop");
        check("s4.drop1", 32'(bus.drop_cnt), 1);
        $display("seq4: inf_seen=%0d drop_cnt=%0d", bus.inf_seen, bus.drop_cnt);

        // Mid-stream reset with in_valid asserted.
        rst_cyc(1'b0, 16'h0, "s5.rst");
        for (int i = 0; i < 5; i++) cyc(16'h0000, 1, 0, 0, "s5.fill");
        rst_cyc(1'b1, 16'h7FC0, "s5.midrst");
        check("s5.level", 32'(bus.level), 0);
        check("s5.valid", 32'(bus.out_valid), 0);
        check("s5.flags", {29'd0, bus.nan_seen, bus.inf_seen, bus.zero_seen}, 0);
        cyc(16'h0, 0, 1, 0, "s5.after");
        $display("seq5: level=%0d after reset", bus.level);

        // Counter saturation, then pointer wrap with continuous push and pop.
        rst_cyc(1'b0, 16'h0, "s6.rst");
        for (int i = 0; i < 8; i++) cyc(16'h3E00 + 16'(i), 1, 0, 0, "s6.fill");
        for (int i = 0; i < 260; i++) cyc(16'h4500, 1, 0, 0, "s6.drop");
        check("s6.sat", 32'(bus.drop_cnt), 32'hFF);
        for (int i = 0; i < 3 * DEPTH; i++) cyc(16'h2000 + 16'(i * 7), 1, 1, 0, "s6.wrap");
        for (int i = 0; i < DEPTH + 1; i++) cyc(16'h0, 0, 1, 0, "s6.drain");
        $display("seq6: drop_cnt=%0d, wrap run complete", bus.drop_cnt);

        // Random traffic against the model.
        rst_cyc(1'b0, 16'h0, "rnd.rst");
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst_cyc(1'($urandom_range(0, 1)), 16'h7FC0, "rnd.rst");
            end else begin
                v = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : 16'($urandom);
                cyc(v, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 40) == 0, "rnd");
            end
        end
        $display("random: 1500 cycles, final level=%0d drop_cnt=%0d", bus.level, bus.drop_cnt);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
